// File: rtl/pmem_loader_pkg.sv
// Shared types and constants for the PMem image loader.
// State codes are plain localparams so legacy tools can read them.
package pmem_loader_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_ADDR_LO = 4'd1;
    localparam state_t S_ADDR_HI = 4'd2;
    localparam state_t S_CNT_LO  = 4'd3;
    localparam state_t S_CNT_HI  = 4'd4;
    localparam state_t S_DAT_LO  = 4'd5;
    localparam state_t S_DAT_HI  = 4'd6;
    localparam state_t S_WRITE   = 4'd7;
    localparam state_t S_CHK     = 4'd8;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Offset of the first data byte, counted from the sync byte.
    localparam int DATA_OFS = 5;

endpackage

// File: rtl/pmem_loader_if.sv
// Byte-stream input, PMem write port and loader status.
// master = loader side, slave = host/PMem side.
interface pmem_loader_if #(
    parameter int ADDR_MSB = 10
);
    logic [7:0]        byte_i;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_MSB:0] ram_addr;
    logic              ram_cen;
    logic [15:0]       ram_din;
    logic [1:0]        ram_wen;
    logic              load_active;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport master (
        input  byte_i, byte_valid,
        output byte_ready,
        output ram_addr, ram_cen, ram_din, ram_wen,
        output load_active, cpu_hold, load_done, load_err
    );

    modport slave (
        output byte_i, byte_valid,
        input  byte_ready,
        input  ram_addr, ram_cen, ram_din, ram_wen,
        input  load_active, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/pmem_loader_timeout.sv
// Inter-byte watchdog: reloads on each accepted byte, counts down
// while enabled, flags the TIMEOUT-th idle cycle.
module pmem_loader_timeout #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam logic [15:0] RELOAD = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = RELOAD;
        else if (en && cnt_q != 16'd0)
            cnt_d = cnt_q - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= RELOAD;
        else     cnt_q <= cnt_d;
    end

    assign expired = en && !load && (cnt_q == 16'd0);

endmodule

// File: rtl/pmem_loader.sv
// Framed byte stream to PMem word writer; holds the CPU in reset
// until a checksum-valid image has been loaded.
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int ADDR_MSB = 10,
    parameter int TIMEOUT  = 65535
) (
    input logic           ram_clk,
    input logic           ram_rst,
    pmem_loader_if.master bus
);
    localparam logic [16:0] DEPTH = 17'(1) << (ADDR_MSB + 1);

    state_t            state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_MSB:0] ram_addr_q, ram_addr_d;
    logic              ram_cen_q, ram_cen_d;
    logic [15:0]       ram_din_q, ram_din_d;
    logic [1:0]        ram_wen_q, ram_wen_d;
    logic              active_q, active_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        ready;
    logic        accept;
    logic        expired;
    logic [7:0]  sum_add;
    logic [15:0] cnt_new;
    logic [16:0] span;

    assign ready   = (state_q != S_WRITE);
    assign accept  = bus.byte_valid && ready;
    assign sum_add = sum_q + bus.byte_i;
    assign cnt_new = {bus.byte_i, cnt_q[7:0]};
    assign span    = {1'b0, addr_q} + {1'b0, cnt_new};

    pmem_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (ram_clk),
        .rst     (ram_rst),
        .load    (accept || state_q == S_WRITE),
        .en      (state_q != S_IDLE && state_q != S_WRITE),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        sum_d      = sum_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_cen_d  = 1'b1;
        ram_wen_d  = 2'b11;
        active_d   = active_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        err_d      = err_q;

        if (accept && state_q != S_IDLE)
            sum_d = sum_add;

        unique case (state_q)
            S_IDLE: if (accept && bus.byte_i == SYNC_BYTE) begin
                err_d    = 1'b0;
                hold_d   = 1'b1;
                active_d = 1'b1;
                sum_d    = 8'h00;
                state_d  = S_ADDR_LO;
            end
            S_ADDR_LO: if (accept) begin
                addr_d[7:0] = bus.byte_i;
                state_d     = S_ADDR_HI;
            end
            S_ADDR_HI: if (accept) begin
                addr_d[15:8] = bus.byte_i;
                state_d      = S_CNT_LO;
            end
            S_CNT_LO: if (accept) begin
                cnt_d[7:0] = bus.byte_i;
                state_d    = S_CNT_HI;
            end
            S_CNT_HI: if (accept) begin
                cnt_d = cnt_new;
                if (span > DEPTH) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_new == 16'd0) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_DAT_LO;
                end
            end
            S_DAT_LO: if (accept) begin
                lo_d    = bus.byte_i;
                state_d = S_DAT_HI;
            end
            S_DAT_HI: if (accept) begin
                ram_cen_d  = 1'b0;
                ram_wen_d  = 2'b00;
                ram_addr_d = addr_q[ADDR_MSB:0];
                ram_din_d  = {bus.byte_i, lo_q};
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_CHK : S_DAT_LO;
            end
            S_CHK: if (accept) begin
                active_d = 1'b0;
                state_d  = S_IDLE;
                if (sum_add == 8'h00) begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stalled host: abandon the frame, CPU stays in reset.
        if (expired) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            hold_d   = 1'b1;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            lo_q       <= '0;
            sum_q      <= '0;
            ram_addr_q <= '0;
            ram_cen_q  <= 1'b1;
            ram_din_q  <= '0;
            ram_wen_q  <= 2'b11;
            active_q   <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            sum_q      <= sum_d;
            ram_addr_q <= ram_addr_d;
            ram_cen_q  <= ram_cen_d;
            ram_din_q  <= ram_din_d;
            ram_wen_q  <= ram_wen_d;
            active_q   <= active_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.byte_ready  = ready;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_cen     = ram_cen_q;
    assign bus.ram_din     = ram_din_q;
    assign bus.ram_wen     = ram_wen_q;
    assign bus.load_active = active_q;
    assign bus.cpu_hold    = hold_q;
    assign bus.load_done   = done_q;
    assign bus.load_err    = err_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Randomized frame bench for pmem_loader with a frame-level
// reference model (expected writes and status per frame).
module tb_pmem_loader;
    import pmem_loader_pkg::*;

    localparam int AMSB  = 10;
    localparam int DEPTH = 1 << (AMSB + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pmem_loader_if #(.ADDR_MSB(AMSB)) bus();

    pmem_loader #(
        .ADDR_MSB (AMSB),
        .TIMEOUT  (16)
    ) dut (
        .ram_clk (clk),
        .ram_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    // Write-strobe and done-pulse log, sampled mid-cycle.
    logic [31:0] wlog[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (!rst && bus.ram_cen == 1'b0) begin
            wlog.push_back({5'b0, bus.ram_addr, bus.ram_din});
            check("strobe_wen", 32'(bus.ram_wen), 32'd0);
        end
        if (!rst && bus.load_done)
            done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.byte_i     = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            ok = bus.byte_ready;
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;
        if (!ok)
            check("byte_accept", 32'd0, 32'd1);
    endtask

    task automatic gap_send(input logic [7:0] b);
        idle($urandom_range(0, 2));
        send_byte(b);
    endtask

    task automatic run_frame(input logic [15:0] addr,
                             input logic [15:0] cnt,
                             input logic [15:0] data[$],
                             input bit bad_chk);
        logic [7:0] hdr[4];
        logic [7:0] sum;
        logic [7:0] chk;
        bit         range_ok;
        bit         ok_exp;
        int         w0, d0, nw;

        range_ok = (int'(addr) + int'(cnt)) <= DEPTH;
        ok_exp   = range_ok && !bad_chk;
        hdr[0] = addr[7:0];
        hdr[1] = addr[15:8];
        hdr[2] = cnt[7:0];
        hdr[3] = cnt[15:8];
        sum = 8'h00;
        for (int i = 0; i < 4; i++)
            sum += hdr[i];
        for (int k = 0; k < int'(cnt) && range_ok; k++)
            sum += data[k][7:0] + data[k][15:8];
        chk = 8'h00 - sum + {7'b0, bad_chk};

        w0 = wlog.size();
        d0 = done_cnt;
        send_byte(SYNC_BYTE);
        check("active_on_sync", 32'(bus.load_active), 32'd1);
        check("err_clr_on_sync", 32'(bus.load_err), 32'd0);
        check("hold_on_sync", 32'(bus.cpu_hold), 32'd1);
        for (int i = 0; i < 4; i++)
            gap_send(hdr[i]);

        if (!range_ok) begin
            check("range_err", 32'(bus.load_err), 32'd1);
            check("range_idle", 32'(bus.load_active), 32'd0);
        end else begin
            for (int k = 0; k < int'(cnt); k++) begin
                gap_send(data[k][7:0]);
                gap_send(data[k][15:8]);
                check("wr_cen", 32'(bus.ram_cen), 32'd0);
                check("wr_addr", 32'(bus.ram_addr), 32'(addr) + 32'(k));
                check("wr_din", 32'(bus.ram_din), 32'(data[k]));
                check("wr_ready_low", 32'(bus.byte_ready), 32'd0);
            end
            gap_send(chk);
            check("chk_done", 32'(bus.load_done), 32'(ok_exp));
            check("chk_hold", 32'(bus.cpu_hold), 32'(!ok_exp));
            check("chk_err", 32'(bus.load_err), 32'(!ok_exp));
            check("chk_active", 32'(bus.load_active), 32'd0);
        end

        idle(3);
        nw = range_ok ? int'(cnt) : 0;
        check("write_count", 32'(wlog.size() - w0), 32'(nw));
        check("done_count", 32'(done_cnt - d0), 32'(ok_exp));
        for (int k = 0; k < nw && w0 + k < wlog.size(); k++) begin
            check("log_addr", 32'(wlog[w0+k][26:16]), 32'(addr) + 32'(k));
            check("log_din", 32'(wlog[w0+k][15:0]), 32'(data[k]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd1);
        check({tag, "_cen"}, 32'(bus.ram_cen), 32'd1);
        check({tag, "_wen"}, 32'(bus.ram_wen), 32'd3);
        check({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
        check({tag, "_din"}, 32'(bus.ram_din), 32'd0);
        check({tag, "_active"}, 32'(bus.load_active), 32'd0);
        check({tag, "_hold"}, 32'(bus.cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(bus.load_done), 32'd0);
        check({tag, "_err"}, 32'(bus.load_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dq[$];
        logic [15:0] a;
        logic [15:0] c;
        int          w0;

        bus.byte_i     = 8'h00;
        bus.byte_valid = 1'b0;
        idle(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        idle(2);

        // Nominal two-word load, then the same frame with a bad checksum.
        dq = {16'h4031, 16'h0A00};
        run_frame(16'h0010, 16'd2, dq, 1'b0);
        run_frame(16'h0010, 16'd2, dq, 1'b1);

        // Range violation at the top of memory.
        run_frame(16'h07FF, 16'd2, dq, 1'b0);

        // Garbage before sync, then an empty frame.
        send_byte(8'h00);
        send_byte(8'h5A);
        check("garbage_idle", 32'(bus.load_active), 32'd0);
        dq = {};
        run_frame(16'h0100, 16'd0, dq, 1'b0);

        // Stall after addr_hi: aborts on the 16th idle cycle.
        send_byte(SYNC_BYTE);
        send_byte(8'h00);
        send_byte(8'h01);
        idle(15);
        check("to_not_yet", 32'(bus.load_err), 32'd0);
        check("to_active", 32'(bus.load_active), 32'd1);
        idle(1);
        check("to_err", 32'(bus.load_err), 32'd1);
        check("to_idle", 32'(bus.load_active), 32'd0);
        check("to_hold", 32'(bus.cpu_hold), 32'd1);
        dq = {16'hBEEF};
        run_frame(16'h0200, 16'd1, dq, 1'b0);

        // Reset between data_lo and data_hi.
        w0 = wlog.size();
        send_byte(SYNC_BYTE);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h34);
        rst = 1'b1;
        idle(2);
        check_reset_outputs("midrst");
        rst = 1'b0;
        idle(2);
        check("midrst_nowrite", 32'(wlog.size() - w0), 32'd0);
        dq = {16'h1234};
        run_frame(16'h0020, 16'd1, dq, 1'b0);

        // Random frames: near-top, wide addresses, bad checksums.
        for (int f = 0; f < 30; f++) begin
            c = 16'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(DEPTH - 6, DEPTH - 1));
                1: a = 16'($urandom_range(0, 16'hFFFF));
                default: a = 16'($urandom_range(0, DEPTH - 1));
            endcase
            dq = {};
            for (int k = 0; k < int'(c); k++)
                dq.push_back(16'($urandom));
            run_frame(a, c, dq, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
